// File: rtl/imem_loader_pkg.sv
// Shared types and stream-format constants for the instruction-memory loader.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam int unsigned HDR_BYTES  = 2;
    localparam int unsigned CSUM_BYTES = 1;
    localparam int unsigned WORD_BYTES = 4;

    // Total number of bytes on the link for a well-formed load of n words.
    function automatic int unsigned stream_bytes(input int unsigned n);
        return HDR_BYTES + WORD_BYTES * n + CSUM_BYTES;
    endfunction

endpackage

// File: rtl/imem_loader_byte_assembler.sv
// Packs accepted payload bytes into little-endian 32-bit words and strobes
// once per completed word, one cycle after its fourth byte.
module byte_assembler (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_data,
    output logic        last_lane,
    output logic        word_stb,
    output logic [31:0] word_data
);

    logic [1:0]  lane_q, lane_d;
    logic [31:0] shift_q, shift_d;
    logic        stb_q, stb_d;

    // Bytes enter at the top and shift down, so the first byte ends in bits 7:0.
    always_comb begin
        lane_d  = lane_q;
        shift_d = shift_q;
        stb_d   = 1'b0;
        if (clear) begin
            lane_d = 2'd0;
        end else if (byte_en) begin
            shift_d = {byte_data, shift_q[31:8]};
            lane_d  = lane_q + 2'd1;
            stb_d   = (lane_q == 2'd3);
        end
    end

    // Lane counter, shift register and word strobe.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lane_q  <= 2'd0;
            shift_q <= 32'd0;
            stb_q   <= 1'b0;
        end else begin
            lane_q  <= lane_d;
            shift_q <= shift_d;
            stb_q   <= stb_d;
        end
    end

    // The shift register holds the finished word during the strobe cycle;
    // the next word's first byte only lands at the end of that cycle.
    assign last_lane = (lane_q == 2'd3);
    assign word_stb  = stb_q;
    assign word_data = shift_q;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream, writes words into the
// instruction RAM and releases the CPU once the checksum matches.
//
// state | meaning
// IDLE  | after reset, waiting for start
// LEN0  | waiting for word-count low byte
// LEN1  | waiting for word-count high byte, range check
// DATA  | receiving payload bytes
// CSUM  | waiting for checksum byte
// DONE  | load verified, CPU released
// ERR   | oversize length or checksum mismatch, CPU held
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int          IDX_W = ADDR_W + 1;
    localparam int unsigned CAP   = 32'd1 << ADDR_W;

    state_e            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [IDX_W-1:0]  n_q, n_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        xor_q, xor_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              hold_q, hold_d;

    logic              in_load;
    logic              xfer;
    logic              start_ok;
    logic              asm_en;
    logic              last_lane;
    logic              word_stb;
    logic [31:0]       word_data;

    assign in_load  = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                      (state_q == ST_DATA) || (state_q == ST_CSUM);
    assign xfer     = byte_valid && in_load;
    assign start_ok = start && !in_load;
    assign asm_en   = xfer && (state_q == ST_DATA);

    byte_assembler u_asm (
        .clk       (clk),
        .rstn      (rstn),
        .clear     (start_ok),
        .byte_en   (asm_en),
        .byte_data (byte_data),
        .last_lane (last_lane),
        .word_stb  (word_stb),
        .word_data (word_data)
    );

    // Next-state logic: header parse, word counting, checksum and status.
    always_comb begin
        logic [15:0] len;
        len      = {byte_data, len_lo_q};
        state_d  = state_q;
        len_lo_d = len_lo_q;
        n_d      = n_q;
        idx_d    = idx_q;
        xor_d    = xor_q;
        addr_d   = addr_q;
        done_d   = done_q;
        err_d    = err_q;
        hold_d   = hold_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    idx_d   = '0;
                    xor_d   = 8'd0;
                    hold_d  = 1'b1;
                end
            end
            ST_LEN0: begin
                if (xfer) begin
                    len_lo_d = byte_data;
                    state_d  = ST_LEN1;
                end
            end
            ST_LEN1: begin
                if (xfer) begin
                    n_d = len[IDX_W-1:0];
                    if (32'(len) > CAP) begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end else if (len == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    xor_d = xor_q ^ byte_data;
                    if (last_lane) begin
                        addr_d = idx_q[ADDR_W-1:0];
                        idx_d  = idx_q + IDX_W'(1);
                        if (idx_d == n_q) begin
                            state_d = ST_CSUM;
                        end
                    end
                end
            end
            ST_CSUM: begin
                if (xfer) begin
                    if (byte_data == xor_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and status registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q  <= ST_IDLE;
            len_lo_q <= 8'd0;
            n_q      <= '0;
            idx_q    <= '0;
            xor_q    <= 8'd0;
            addr_q   <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            hold_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            n_q      <= n_d;
            idx_q    <= idx_d;
            xor_q    <= xor_d;
            addr_q   <= addr_d;
            done_q   <= done_d;
            err_q    <= err_d;
            hold_q   <= hold_d;
        end
    end

    assign byte_ready = in_load;
    assign busy       = in_load;
    assign imem_we    = word_stb;
    assign imem_addr  = addr_q;
    assign imem_wdata = word_data;
    assign cpu_hold   = hold_q;
    assign done       = done_q;
    assign err        = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader with a stream-level reference model.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int ADDR_W = 7;
    localparam int CAP    = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic              byte_valid = 1'b0;
    logic [7:0]        byte_data = 8'd0;
    logic              byte_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int both_set = 0;

    logic [7:0]        stream[$];
    logic [ADDR_W-1:0] got_addr[$];
    logic [31:0]       got_data[$];
    int                got_cyc[$];
    logic [ADDR_W-1:0] exp_addr[$];
    logic [31:0]       exp_data[$];
    logic              exp_done;
    logic              exp_err;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (imem_we) begin
            got_addr.push_back(imem_addr);
            got_data.push_back(imem_wdata);
            got_cyc.push_back(cyc);
        end
        if (done && err) both_set++;
    end

    // Random well-formed stream of n words, optionally with a bad checksum.
    task automatic build(input int n, input bit bad_csum);
        logic [7:0] x;
        logic [7:0] b;
        logic [15:0] n16;
        n16 = 16'(n);
        stream.delete();
        stream.push_back(n16[7:0]);
        stream.push_back(n16[15:8]);
        x = 8'd0;
        for (int i = 0; i < 4 * n; i++) begin
            b = 8'($urandom);
            stream.push_back(b);
            x ^= b;
        end
        stream.push_back(bad_csum ? (x ^ 8'h01) : x);
    endtask

    // Reference: decode the stream from its format rules.
    task automatic model();
        int n;
        logic [7:0] x;
        logic [31:0] w;
        exp_addr.delete();
        exp_data.delete();
        n = int'({stream[1], stream[0]});
        if (n > CAP) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
            return;
        end
        x = 8'd0;
        for (int k = 0; k < n; k++) begin
            w = 32'd0;
            for (int j = 0; j < 4; j++) begin
                w = w | (32'(stream[2 + 4 * k + j]) << (8 * j));
                x ^= stream[2 + 4 * k + j];
            end
            exp_addr.push_back(ADDR_W'(k));
            exp_data.push_back(w);
        end
        exp_done = (stream[2 + 4 * n] == x);
        exp_err  = !exp_done;
    endtask

    task automatic clear_got();
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Entered and left at a falling edge; one transfer per call.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!byte_ready) begin
            checks++;
            $display("FAIL send_byte_timeout ready=%b required 1", byte_ready);
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_range(input int first, input int last, input int maxgap);
        for (int i = first; i <= last; i++)
            send_byte(stream[i], $urandom_range(maxgap, 0));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            checks++;
            $display("FAIL wait_idle_timeout busy=%b required 0", busy);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({byte_ready, imem_we, busy, done, err, cpu_hold} !== 6'b000001)
            $display("FAIL reset_ctrl got rdy/we/busy/done/err/hold=%b required 000001",
                     {byte_ready, imem_we, busy, done, err, cpu_hold});
        else passes++;
        checks++;
        if ({imem_addr, imem_wdata} !== '0)
            $display("FAIL reset_data got addr=%h wdata=%h required 0/0", imem_addr, imem_wdata);
        else passes++;
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                   8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
        model();
        clear_got();
        pulse_start();
        checks++;
        if ({busy, cpu_hold, byte_ready, done, err} !== 5'b11100)
            $display("FAIL basic_start got busy/hold/rdy/done/err=%b required 11100",
                     {busy, cpu_hold, byte_ready, done, err});
        else passes++;
        send_range(0, stream.size() - 1, 0);
        wait_idle();
        checks++;
        if (got_data.size() != 2)
            $display("FAIL basic_count got %0d required 2", got_data.size());
        else begin
            if (got_addr[0] !== 7'd0 || got_data[0] !== 32'h00500093 ||
                got_addr[1] !== 7'd1 || got_data[1] !== 32'h00A00113)
                $display("FAIL basic_words got %h@%0d %h@%0d required 00500093@0 00a00113@1",
                         got_data[0], got_addr[0], got_data[1], got_addr[1]);
            else passes++;
        end
        checks++;
        if ({done, err, cpu_hold, busy} !== {exp_done, exp_err, !exp_done, 1'b0})
            $display("FAIL basic_status got done/err/hold/busy=%b required %b",
                     {done, err, cpu_hold, busy}, {exp_done, exp_err, !exp_done, 1'b0});
        else passes++;
    endtask

    task automatic test_gaps(input int n, input bit bad);
        if (n > 0) build(n, bad);
        else stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                        8'h13, 8'h01, 8'hA0, 8'h00, 8'h71};
        model();
        clear_got();
        pulse_start();
        send_range(0, stream.size() - 1, 3);
        wait_idle();
        checks++;
        if (got_data.size() != exp_data.size())
            $display("FAIL gaps_count got %0d required %0d", got_data.size(), exp_data.size());
        else passes++;
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            checks++;
            if (got_addr[i] !== exp_addr[i] || got_data[i] !== exp_data[i])
                $display("FAIL gaps_word%0d got %h@%0d required %h@%0d",
                         i, got_data[i], got_addr[i], exp_data[i], exp_addr[i]);
            else passes++;
        end
        checks++;
        if ({done, err, cpu_hold, busy} !== {exp_done, exp_err, !exp_done, 1'b0})
            $display("FAIL gaps_status got done/err/hold/busy=%b required %b",
                     {done, err, cpu_hold, busy}, {exp_done, exp_err, !exp_done, 1'b0});
        else passes++;
    endtask

    task automatic test_csum_fault();
        stream = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                   8'h13, 8'h01, 8'hA0, 8'h00, 8'h70};
        model();
        clear_got();
        pulse_start();
        checks++;
        if ({done, err} !== 2'b00)
            $display("FAIL csum_start_clear got done/err=%b required 00", {done, err});
        else passes++;
        send_range(0, stream.size() - 1, 1);
        wait_idle();
        checks++;
        if (got_data.size() != 2 || got_data[0] !== exp_data[0] || got_data[1] !== exp_data[1])
            $display("FAIL csum_words got count %0d required 2 matching words", got_data.size());
        else passes++;
        checks++;
        if ({done, err, cpu_hold} !== 3'b011)
            $display("FAIL csum_status got done/err/hold=%b required 011", {done, err, cpu_hold});
        else passes++;
    endtask

    task automatic test_zero_len();
        stream = '{8'h00, 8'h00, 8'h00};
        model();
        clear_got();
        pulse_start();
        send_range(0, 2, 2);
        wait_idle();
        checks++;
        if (got_data.size() != 0 || {done, err, cpu_hold} !== {exp_done, exp_err, 1'b0})
            $display("FAIL zero_len got writes=%0d done/err/hold=%b required 0 100",
                     got_data.size(), {done, err, cpu_hold});
        else passes++;
    endtask

    task automatic test_oversize();
        stream = '{8'h81, 8'h00};
        model();
        clear_got();
        pulse_start();
        send_range(0, 1, 0);
        checks++;
        if ({byte_ready, busy, done, err, cpu_hold} !== {3'b000, exp_err, 1'b1})
            $display("FAIL oversize got rdy/busy/done/err/hold=%b required 00011",
                     {byte_ready, busy, done, err, cpu_hold});
        else passes++;
        repeat (4) @(negedge clk);
        checks++;
        if (got_data.size() != 0)
            $display("FAIL oversize_writes got %0d required 0", got_data.size());
        else passes++;
    endtask

    task automatic test_full_capacity();
        int bad_gap;
        build(CAP, 1'b0);
        model();
        clear_got();
        pulse_start();
        send_range(0, stream.size() - 1, 0);
        wait_idle();
        checks++;
        if (got_data.size() != CAP || got_addr[CAP-1] !== ADDR_W'(CAP - 1))
            $display("FAIL full_count got %0d writes required %0d ending at %0d",
                     got_data.size(), CAP, CAP - 1);
        else passes++;
        bad_gap = 0;
        for (int i = 1; i < got_cyc.size(); i++)
            if (got_cyc[i] - got_cyc[i-1] != 4) bad_gap++;
        checks++;
        if (bad_gap != 0)
            $display("FAIL full_spacing got %0d irregular write gaps required 0", bad_gap);
        else passes++;
        checks++;
        if ({done, err, cpu_hold} !== 3'b100)
            $display("FAIL full_status got done/err/hold=%b required 100", {done, err, cpu_hold});
        else passes++;
    endtask

    task automatic test_start_while_busy();
        build(3, 1'b0);
        model();
        clear_got();
        pulse_start();
        send_range(0, 5, 0);
        pulse_start();
        send_range(6, stream.size() - 1, 1);
        wait_idle();
        checks++;
        if (got_data.size() != 3 || got_data[2] !== exp_data[2] || got_addr[2] !== exp_addr[2])
            $display("FAIL busy_start got %0d writes required 3 with last %h", got_data.size(),
                     exp_data[2]);
        else passes++;
        checks++;
        if ({done, err} !== 2'b10)
            $display("FAIL busy_start_status got done/err=%b required 10", {done, err});
        else passes++;
    endtask

    task automatic test_reset_mid();
        build(2, 1'b0);
        model();
        clear_got();
        pulse_start();
        send_range(0, 6, 0);
        rstn = 1'b0;
        @(negedge clk);
        checks++;
        if ({byte_ready, imem_we, busy, done, err, cpu_hold} !== 6'b000001 ||
            {imem_addr, imem_wdata} !== '0)
            $display("FAIL reset_mid got rdy/we/busy/done/err/hold=%b addr=%h data=%h required 000001 0 0",
                     {byte_ready, imem_we, busy, done, err, cpu_hold}, imem_addr, imem_wdata);
        else passes++;
        checks++;
        if (got_data.size() != 1 || got_data[0] !== exp_data[0])
            $display("FAIL reset_mid_writes got %0d writes required 1 of %h",
                     got_data.size(), exp_data[0]);
        else passes++;
        rstn = 1'b1;
        @(negedge clk);
        test_gaps(4, 1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps(0, 1'b0);
        test_gaps(5, 1'b0);
        test_gaps(3, 1'b1);
        test_csum_fault();
        test_zero_len();
        test_oversize();
        test_full_capacity();
        test_start_while_busy();
        test_reset_mid();
        checks++;
        if (both_set != 0)
            $display("FAIL done_err_exclusive got %0d cycles with both set required 0", both_set);
        else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout");
        $fatal(1, "time limit");
    end

endmodule
